msrv32_alu_arbiter: RTL and testbench
=====================================

MSRV32_ALU_ARBITER -- requirements
Module: msrv32_alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width.
REQ-002 Port ms_riscv32_mp_clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port ms_riscv32_mp_rst_in, input, 1, reset, synchronous and active-high.
REQ-004 Port reqN_valid_in (N=0,1), input, 1, requester N presents an operation.
REQ-005 Port reqN_ready_out (N=0,1), output, 1, the arbiter accepts requester N's operation this cycle.
REQ-006 Port reqN_op_1_in (N=0,1), input, WIDTH, operand 1.
REQ-007 Port reqN_op_2_in (N=0,1), input, WIDTH, operand 2.
REQ-008 Port reqN_opcode_in (N=0,1), input, 4, ALU operation code.
REQ-009 Port rsp_valid_out, output, 1, the response register holds a result.
REQ-010 Port rsp_id_out, output, 1, index of the requester that owns the response.
REQ-011 Port rsp_result_out, output, WIDTH, ALU result.
REQ-012 Port rsp_ready_in, input, 1, the consumer takes the response this cycle.

Function
REQ-013 A request SHALL transfer in a cycle where both reqN_valid_in and reqN_ready_out are 1; a response SHALL transfer in a cycle where both rsp_valid_out and rsp_ready_in are 1.
REQ-014 Slot free: slot_free = !rsp_valid_out | rsp_ready_in, allowing accept and drain in the same cycle.
REQ-015 Grant: if exactly one requester is valid, it is granted; if both are valid, grant the requester not granted by the last accepted transfer (round-robin).
REQ-016 reqN_ready_out SHALL be slot_free AND grant==N; the non-granted requester's ready SHALL be 0.
REQ-017 The round-robin pointer SHALL update only on an accepted transfer, never on a stall.
REQ-018 The ALU SHALL be fed combinationally from the granted requester's operands and opcode.
REQ-019 On accept at edge k, after edge k: rsp_valid_out=1, rsp_id_out=N, rsp_result_out=ALU result; latency is 1 cycle.
REQ-020 With rsp_valid_out=1 and rsp_ready_in=0, rsp_valid_out, rsp_id_out and rsp_result_out SHALL hold stable, and both ready outputs SHALL be 0.
REQ-021 With a drain and no accept in the same cycle, rsp_valid_out SHALL go 0 next cycle.
REQ-022 ALU operations: ADD 0000; SUB 1000; SLT 0010 (signed less-than, 1/0); SLTU 0011 (unsigned); AND 0111; OR 0110; XOR 0100; SLL 0001; SRL 0101; SRA 1101. Shift amount = op_2[4:0].
REQ-023 An undefined opcode SHALL return result 0 and still complete normally; the datapath SHALL be latch-free.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-025 Requester inputs SHALL be ignored while reqN_valid_in=0.

Reset
REQ-026 While ms_riscv32_mp_rst_in=1 at a clock edge, rsp_valid_out=0, rsp_id_out=0 and rsp_result_out=0 SHALL be set, and the round-robin pointer SHALL be set so requester 0 wins the first tie.
REQ-027 Both ready outputs SHALL be 0 while reset is asserted.
REQ-028 Reset mid-operation SHALL discard any pending response without handshake.

Structure
REQ-029 WIDTH and the ALU opcode constants SHALL live in the shared package msrv32_pkg, used by both the ALU and the arbiter.
REQ-030 The arbiter SHALL instantiate exactly one msrv32_alu as its datapath sub-module.
REQ-031 Arbitration, the round-robin pointer and the response register SHALL reside in msrv32_alu_arbiter.

Verification
REQ-032 Single request: req0 ADD 0x00000005+0x00000003, rsp_ready_in=1 -> next cycle rsp_valid_out=1, rsp_id_out=0, rsp_result_out=0x00000008.
REQ-033 Contention: both valid for 4 cycles, rsp_ready_in=1 -> grants alternate 0,1,0,1 and rsp_id_out follows the same sequence one cycle later.
REQ-034 Backpressure: rsp_ready_in=0 for 3 cycles after an accept -> response held stable, both ready outputs 0, round-robin pointer unchanged; on release, the next grant goes to the other requester.
REQ-035 Signed compare: SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLT 0x00000001 vs 0x80000000 -> 0; SLTU 0x00000001 vs 0x80000000 -> 1; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-036 Undefined opcode 1111 -> result 0x00000000 with a normal handshake.
REQ-037 Reset with rsp_valid_out=1 -> next cycle rsp_valid_out=0; the first subsequent tie goes to requester 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 ALU datapath: default data width, ALU opcodes
// and requester identifiers.
package msrv32_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/msrv32_alu.sv
// Combinational RV32 integer ALU; undefined opcodes yield zero.
module msrv32_alu #(
    parameter int unsigned WIDTH = msrv32_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] op_1_in,
    input  logic [WIDTH-1:0] op_2_in,
    input  logic [3:0]       opcode_in,
    output logic [WIDTH-1:0] result_out
);
    import msrv32_pkg::*;

    logic [4:0] shamt;

    assign shamt = op_2_in[4:0];

    always_comb begin
        result_out = '0;
        case (opcode_in)
            ALU_ADD:  result_out = op_1_in + op_2_in;
            ALU_SUB:  result_out = op_1_in - op_2_in;
            ALU_SLT:  result_out = {{(WIDTH-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
            ALU_SLTU: result_out = {{(WIDTH-1){1'b0}}, (op_1_in < op_2_in)};
            ALU_AND:  result_out = op_1_in & op_2_in;
            ALU_OR:   result_out = op_1_in | op_2_in;
            ALU_XOR:  result_out = op_1_in ^ op_2_in;
            ALU_SLL:  result_out = op_1_in << shamt;
            ALU_SRL:  result_out = op_1_in >> shamt;
            ALU_SRA:  result_out = $unsigned($signed(op_1_in) >>> shamt);
            default:  result_out = '0;
        endcase
    end

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a single-entry
// response register (1-cycle latency, accept and drain in the same cycle).
module msrv32_alu_arbiter #(
    parameter int unsigned WIDTH = msrv32_pkg::WIDTH
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [WIDTH-1:0] req0_op_1_in,
    input  logic [WIDTH-1:0] req0_op_2_in,
    input  logic [3:0]       req0_opcode_in,
    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [WIDTH-1:0] req1_op_1_in,
    input  logic [WIDTH-1:0] req1_op_2_in,
    input  logic [3:0]       req1_opcode_in,
    output logic             rsp_valid_out,
    output logic             rsp_id_out,
    output logic [WIDTH-1:0] rsp_result_out,
    input  logic             rsp_ready_in
);
    import msrv32_pkg::*;

    logic             slot_free;
    logic             accept;
    req_id_e          grant;
    req_id_e          last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    req_id_e          rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [WIDTH-1:0] alu_op_1, alu_op_2, alu_result;
    logic [3:0]       alu_opcode;

    assign slot_free = !rsp_valid_q || rsp_ready_in;

    // On a tie the requester that did not win the previous accepted transfer wins.
    always_comb begin
        grant = REQ_0;
        if (req0_valid_in && req1_valid_in) begin
            grant = (last_grant_q == REQ_0) ? REQ_1 : REQ_0;
        end else if (req1_valid_in) begin
            grant = REQ_1;
        end
    end

    always_comb begin
        req0_ready_out = !ms_riscv32_mp_rst_in && slot_free && (grant == REQ_0);
        req1_ready_out = !ms_riscv32_mp_rst_in && slot_free && (grant == REQ_1);
        accept = (req0_ready_out && req0_valid_in) || (req1_ready_out && req1_valid_in);
    end

    always_comb begin
        alu_op_1   = req0_op_1_in;
        alu_op_2   = req0_op_2_in;
        alu_opcode = req0_opcode_in;
        if (grant == REQ_1) begin
            alu_op_1   = req1_op_1_in;
            alu_op_2   = req1_op_2_in;
            alu_opcode = req1_opcode_in;
        end
    end

    msrv32_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op_1_in   (alu_op_1),
        .op_2_in   (alu_op_2),
        .opcode_in (alu_opcode),
        .result_out(alu_result)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant;
            rsp_result_d = alu_result;
            last_grant_d = grant;
        end else if (rsp_ready_in) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Pointer resets to REQ_1 so that requester 0 wins the first tie.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= REQ_0;
            rsp_result_q <= '0;
            last_grant_q <= REQ_1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_id_out     = rsp_id_q;
    assign rsp_result_out = rsp_result_q;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Self-checking bench for msrv32_alu_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_msrv32_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid_in, req1_valid_in;
    logic        req0_ready_out, req1_ready_out;
    logic [31:0] req0_op_1_in, req0_op_2_in, req1_op_1_in, req1_op_2_in;
    logic [3:0]  req0_opcode_in, req1_opcode_in;
    logic        rsp_valid_out, rsp_id_out, rsp_ready_in;
    logic [31:0] rsp_result_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the pending response and the last winner.
    logic        m_valid;
    logic        m_id;
    logic [31:0] m_res;
    logic        m_last;

    always #5 clk = ~clk;

    msrv32_alu_arbiter #(
        .WIDTH(32)
    ) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .req0_valid_in       (req0_valid_in),
        .req0_ready_out      (req0_ready_out),
        .req0_op_1_in        (req0_op_1_in),
        .req0_op_2_in        (req0_op_2_in),
        .req0_opcode_in      (req0_opcode_in),
        .req1_valid_in       (req1_valid_in),
        .req1_ready_out      (req1_ready_out),
        .req1_op_1_in        (req1_op_1_in),
        .req1_op_2_in        (req1_op_2_in),
        .req1_opcode_in      (req1_opcode_in),
        .rsp_valid_out       (rsp_valid_out),
        .rsp_id_out          (rsp_id_out),
        .rsp_result_out      (rsp_result_out),
        .rsp_ready_in        (rsp_ready_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] r;
        s = b[4:0];
        case (op)
            4'd0:  r = a + b;
            4'd8:  r = a - b;
            4'd2:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a & b;
            4'd6:  r = a | b;
            4'd4:  r = a ^ b;
            4'd1:  r = a << s;
            4'd5:  r = a >> s;
            4'd13: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (n == 0) begin
            req0_valid_in = v; req0_op_1_in = a; req0_op_2_in = b; req0_opcode_in = op;
        end else begin
            req1_valid_in = v; req1_op_1_in = a; req1_op_2_in = b; req1_opcode_in = op;
        end
    endtask

    // One clock: check readies against the model, clock, advance model, check response.
    task automatic cycle(input logic rst_v, input logic rr_v);
        logic sf, g, e0, e1, acc;
        rst = rst_v;
        rsp_ready_in = rr_v;
        #1;
        sf = !m_valid || rr_v;
        if (req0_valid_in && req1_valid_in) g = !m_last;
        else g = req1_valid_in;
        e0 = !rst_v && sf && !g;
        e1 = !rst_v && sf && g;
        check("req0_ready", 32'(req0_ready_out), 32'(e0));
        check("req1_ready", 32'(req1_ready_out), 32'(e1));
        acc = (e0 && req0_valid_in) || (e1 && req1_valid_in);
        if (rst_v) begin
            m_valid = 1'b0; m_id = 1'b0; m_res = 32'd0; m_last = 1'b1;
        end else if (acc) begin
            m_valid = 1'b1;
            m_id    = g;
            m_res   = g ? alu_ref(req1_opcode_in, req1_op_1_in, req1_op_2_in)
                        : alu_ref(req0_opcode_in, req0_op_1_in, req0_op_2_in);
            m_last  = g;
        end else if (rr_v) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid_out), 32'(m_valid));
        check("rsp_id", 32'(rsp_id_out), 32'(m_id));
        check("rsp_result", rsp_result_out, m_res);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom % 5)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_opcode();
        logic [3:0] ops [10] = '{4'd0, 4'd8, 4'd2, 4'd3, 4'd7, 4'd6, 4'd4, 4'd1, 4'd5, 4'd13};
        if ($urandom % 8 == 0) return 4'($urandom);
        return ops[$urandom % 10];
    endfunction

    initial begin
        logic [31:0] held;
        m_valid = 1'b0; m_id = 1'b0; m_res = 32'd0; m_last = 1'b1;
        rst = 1'b1;
        rsp_ready_in = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);

        // Single request: 5 + 3
        set_req(0, 1'b1, 32'd5, 32'd3, 4'b0000);
        cycle(1'b0, 1'b1);
        check("add_valid", 32'(rsp_valid_out), 32'd1);
        check("add_id", 32'(rsp_id_out), 32'd0);
        check("add_result", rsp_result_out, 32'd8);

        // Signed/unsigned compares and arithmetic shift
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
        cycle(1'b0, 1'b1);
        check("slt_neg", rsp_result_out, 32'd1);
        set_req(0, 1'b1, 32'd1, 32'h8000_0000, 4'b0010);
        cycle(1'b0, 1'b1);
        check("slt_pos", rsp_result_out, 32'd0);
        set_req(0, 1'b1, 32'd1, 32'h8000_0000, 4'b0011);
        cycle(1'b0, 1'b1);
        check("sltu", rsp_result_out, 32'd1);
        set_req(0, 1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        cycle(1'b0, 1'b1);
        check("sra", rsp_result_out, 32'hF800_0000);
        set_req(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);
        cycle(1'b0, 1'b1);
        check("undef_valid", 32'(rsp_valid_out), 32'd1);
        check("undef_result", rsp_result_out, 32'd0);

        // Contention after reset: grants alternate starting with requester 0
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        cycle(1'b1, 1'b1);
        set_req(0, 1'b1, 32'd10, 32'd1, 4'b0000);
        set_req(1, 1'b1, 32'd20, 32'd2, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1);
            check("contention_id", 32'(rsp_id_out), 32'(i % 2));
        end

        // Backpressure: accept from req0, stall three cycles, then req1 wins
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(0, 1'b1, 32'd7, 32'd9, 4'b0110);
        cycle(1'b0, 1'b1);
        held = rsp_result_out;
        check("bp_accept", held, 32'd15);
        set_req(1, 1'b1, 32'd3, 32'd4, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            check("bp_hold_result", rsp_result_out, held);
            check("bp_hold_id", 32'(rsp_id_out), 32'd0);
            check("bp_ready0", 32'(req0_ready_out), 32'd0);
            check("bp_ready1", 32'(req1_ready_out), 32'd0);
        end
        rsp_ready_in = 1'b1;
        #1;
        check("bp_release_ready1", 32'(req1_ready_out), 32'd1);
        cycle(1'b0, 1'b1);
        check("bp_release_id", 32'(rsp_id_out), 32'd1);
        check("bp_release_result", rsp_result_out, 32'd7);

        // Reset with a pending response, then first tie goes to requester 0
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("rst_valid", 32'(rsp_valid_out), 32'd0);
        rst = 1'b0;
        rsp_ready_in = 1'b1;
        #1;
        check("rst_tie_ready0", 32'(req0_ready_out), 32'd1);
        check("rst_tie_ready1", 32'(req1_ready_out), 32'd0);
        cycle(1'b0, 1'b1);
        check("rst_tie_id", 32'(rsp_id_out), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_req(0, ($urandom % 100) < 60, rand_operand(), rand_operand(), rand_opcode());
            set_req(1, ($urandom % 100) < 60, rand_operand(), rand_operand(), rand_opcode());
            cycle(($urandom % 100) < 2, ($urandom % 100) < 70);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
